// File: rtl/imem_uart_loader_if.sv
// rtl/imem_uart_loader_if.sv - byte stream in, instruction-memory write port out
interface imem_uart_loader_if #(
  parameter int ADDR_WIDTH = 30
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  // master is the loader; slave is the UART receiver plus instruction memory
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - loads a framed big-endian program image from UART into instruction memory
module imem_uart_loader #(
  parameter int          ADDR_WIDTH     = 30,
  parameter int          BASE_ADDR      = 0,
  parameter int          MAX_WORDS      = 4096,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_uart_loader_if.master   bus,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          words_loaded
);

  localparam int                TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]       MAX_W    = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_CSUM
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     count_q;
  logic [1:0]      byte_idx_q;
  logic [7:0]      csum_q;
  logic [TW-1:0]   tmo_q;

  logic        xfer;
  logic        counting;
  logic        tmo_fire;
  logic [15:0] count_full;
  logic        count_over;

  assign xfer       = bus.rx_valid & bus.rx_ready;
  assign counting   = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
  assign tmo_fire   = counting && !xfer && (tmo_q == TMO_LAST);
  assign count_full = {count_q[15:8], bus.rx_data};
  assign count_over = {1'b0, count_full} > MAX_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (xfer && bus.rx_data == SYNC_BYTE) state_d = S_CNT_HI;
      S_CNT_HI: if (xfer) state_d = S_CNT_LO;
      S_CNT_LO: if (xfer) begin
        if (count_over)              state_d = S_IDLE;
        else if (count_full == 16'd0) state_d = S_CSUM;
        else                         state_d = S_DATA;
      end
      S_DATA:   if (xfer && byte_idx_q == 2'd3) state_d = S_WRITE;
      S_WRITE:  state_d = (words_loaded + 16'd1 == count_q) ? S_CSUM : S_DATA;
      S_CSUM:   if (xfer) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (tmo_fire) state_d = S_IDLE;
  end

  always_comb begin
    bus.rx_ready = (state_q != S_WRITE);
    bus.imem_we  = (state_q == S_WRITE);
    busy         = (state_q != S_IDLE);
    cpu_hold     = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.imem_addr  <= ADDR_WIDTH'(BASE_ADDR);
      bus.imem_wdata <= 32'd0;
      count_q        <= 16'd0;
      byte_idx_q     <= 2'd0;
      csum_q         <= 8'd0;
      tmo_q          <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= 16'd0;
    end else begin
      // idle gap counter only runs while a frame is waiting on the receiver
      if (xfer || !counting) tmo_q <= '0;
      else                   tmo_q <= tmo_q + 1'b1;

      case (state_q)
        S_IDLE: if (xfer && bus.rx_data == SYNC_BYTE) begin
          done          <= 1'b0;
          error         <= 1'b0;
          words_loaded  <= 16'd0;
          csum_q        <= 8'd0;
          byte_idx_q    <= 2'd0;
          bus.imem_addr <= ADDR_WIDTH'(BASE_ADDR);
        end
        S_CNT_HI: if (xfer) count_q[15:8] <= bus.rx_data;
        S_CNT_LO: if (xfer) begin
          count_q[7:0] <= bus.rx_data;
          if (count_over) error <= 1'b1;
        end
        S_DATA: if (xfer) begin
          bus.imem_wdata <= {bus.imem_wdata[23:0], bus.rx_data};
          csum_q         <= csum_q + bus.rx_data;
          byte_idx_q     <= byte_idx_q + 2'd1;
        end
        S_WRITE: begin
          words_loaded  <= words_loaded + 16'd1;
          bus.imem_addr <= bus.imem_addr + 1'b1;
        end
        S_CSUM: if (xfer) begin
          if (bus.rx_data == csum_q) done  <= 1'b1;
          else                       error <= 1'b1;
        end
        default: ;
      endcase

      if (tmo_fire) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - scoreboard bench for imem_uart_loader
module tb_imem_uart_loader;

  localparam int             AW   = 30;
  localparam logic [AW-1:0]  BASE = 30'h100;
  localparam int             TMO  = 100;
  localparam int             MAXW = 4096;
  localparam logic [7:0]     SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_hold, busy, done, error;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  imem_uart_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_uart_loader #(
    .ADDR_WIDTH(AW), .BASE_ADDR(int'(BASE)), .MAX_WORDS(MAXW),
    .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t           exp_q[$];
  logic [31:0]   img[$];
  logic [AW-1:0] exp_addr;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // every write the DUT issues must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && bus.imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(bus.imem_addr), 64'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.imem_addr), 64'(e.a));
        check("wr_data", 64'(bus.imem_wdata), 64'(e.d));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic took;
    took = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 4 && !took; i++) begin
      took = bus.rx_ready;
      @(negedge clk);
    end
    if (!took) check("rx_ready_stuck", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input bit bad_csum);
    logic [15:0] cnt;
    logic [7:0]  sum;
    logic [7:0]  b;
    cnt = 16'(img.size());
    sum = 8'd0;
    send_byte(SYNC);
    exp_addr = BASE;
    check("hold_after_sync", 64'(cpu_hold), 64'd1);
    send_byte(cnt[15:8]);
    send_byte(cnt[7:0]);
    foreach (img[w]) begin
      exp_q.push_back('{a: exp_addr, d: img[w]});
      exp_addr = exp_addr + 1'b1;
      for (int k = 3; k >= 0; k--) begin
        b = img[w][8*k +: 8];
        sum = sum + b;
        send_byte(b);
      end
      check("we_latency", 64'(bus.imem_we), 64'd1);
    end
    check("hold_before_csum", 64'(cpu_hold), 64'd1);
    send_byte(bad_csum ? sum + 8'd1 : sum);
    bus.rx_valid = 1'b0;
    check("busy_after_csum", 64'(busy), 64'd0);
    check("hold_after_csum", 64'(cpu_hold), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_status(input string tag, input bit d, input bit e, input int wl);
    check({tag, "_done"}, 64'(done), 64'(d));
    check({tag, "_error"}, 64'(error), 64'(e));
    check({tag, "_words"}, 64'(words_loaded), 64'(wl));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd1);
    check({tag, "_we"}, 64'(bus.imem_we), 64'd0);
    check({tag, "_addr"}, 64'(bus.imem_addr), 64'(BASE));
    check({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    check_status(tag, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1);
  end

  initial begin
    int k;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // two-word image, good then bad checksum
    img = '{32'h3c1d1000, 32'h0c000c03};
    send_frame(1'b0);
    check_status("frame_good", 1'b1, 1'b0, 2);
    send_frame(1'b1);
    check_status("frame_bad_csum", 1'b0, 1'b1, 2);

    // oversize counts abort right after COUNT_LO
    send_byte(SYNC); send_byte(8'h20); send_byte(8'h00);
    bus.rx_valid = 1'b0;
    check("over_busy", 64'(busy), 64'd0);
    check_status("over_2000", 1'b0, 1'b1, 0);
    send_byte(8'h00); send_byte(8'h00);
    bus.rx_valid = 1'b0;
    send_byte(SYNC); send_byte(8'h10); send_byte(8'h01);
    bus.rx_valid = 1'b0;
    check_status("over_1001", 1'b0, 1'b1, 0);

    // exactly MAX_WORDS is accepted, then left to time out
    send_byte(SYNC); send_byte(8'h10); send_byte(8'h00);
    bus.rx_valid = 1'b0;
    check("max_busy", 64'(busy), 64'd1);
    check("max_error", 64'(error), 64'd0);
    k = 0;
    while (k < 300 && !error) begin @(negedge clk); k++; end
    check("max_then_timeout", 64'(error), 64'd1);

    // junk before sync is dropped
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    img = '{32'hdeadbeef};
    send_frame(1'b0);
    check_status("junk_frame", 1'b1, 1'b0, 1);

    // zero-length image
    img.delete();
    send_frame(1'b0);
    check_status("zero_frame", 1'b1, 1'b0, 0);

    // stall after five data bytes
    send_byte(SYNC); send_byte(8'h00); send_byte(8'h02);
    exp_q.push_back('{a: BASE, d: 32'h11223344});
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    bus.rx_valid = 1'b0;
    k = 0;
    while (k < 300 && !error) begin @(negedge clk); k++; end
    check("timeout_cycles", 64'(k), 64'(TMO));
    check("timeout_busy", 64'(busy), 64'd0);
    check("timeout_hold", 64'(cpu_hold), 64'd0);
    check_status("timeout", 1'b0, 1'b1, 1);
    check("timeout_sb", 64'(exp_q.size()), 64'd0);

    // asynchronous reset in the middle of DATA, receiver still pushing
    send_byte(SYNC); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB);
    bus.rx_data  = 8'hCC;
    bus.rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    repeat (2) @(negedge clk);
    check_reset_values("held_reset");
    bus.rx_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // sync byte values inside the payload are plain data
    img = '{32'ha5a5a5a5, 32'h00a500ff, 32'h12345678};
    send_frame(1'b0);
    check_status("after_reset", 1'b1, 1'b0, 3);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
